pc_fetch_ctrl: RTL

//  Program-counter and instruction-fetch controller for the RV32 pipeline.

---
 rtl/pc_fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - RV32 PC owner and in-order instruction fetch controller
// Issues imem fetches, buffers returned words with their PC, and flushes on redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        flush_if,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_next;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding, buffered, drop_cnt;
  logic [CW:0]   occupancy;

  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [PW-1:0] buf_rd, buf_wr;
  logic [31:0]   pcq      [DEPTH];
  logic [PW-1:0] pcq_rd, pcq_wr;

  logic accept, rsp_ok, rsp_keep, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign occupancy = {1'b0, outstanding} + {1'b0, buffered};

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    if (state == BOOT) begin
      state_next = RUN;
    end
    if (state == RUN && !redirect_valid && occupancy < DEPTH_W) begin
      imem_req_valid = 1'b1;
    end
  end

  assign imem_req_addr = pc;
  assign accept        = imem_req_valid & imem_req_ready;
  // A response with nothing in flight is a protocol error and is ignored entirely.
  assign rsp_ok        = imem_rsp_valid & (outstanding != '0);
  assign rsp_keep      = rsp_ok & (drop_cnt == '0);
  assign pop           = instr_valid & instr_ready;

  assign instr_valid = (buffered != '0);
  assign instr       = instr_valid ? buf_data[buf_rd] : '0;
  assign instr_pc    = instr_valid ? buf_pc[buf_rd]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      outstanding   <= '0;
      buffered      <= '0;
      drop_cnt      <= '0;
      buf_rd        <= '0;
      buf_wr        <= '0;
      pcq_rd        <= '0;
      pcq_wr        <= '0;
      flush_if      <= 1'b0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state        <= state_next;
      flush_if     <= redirect_valid;
      misalign_exc <= redirect_valid & (redirect_target[1:0] != 2'b00);
      outstanding  <= outstanding + CW'(accept) - CW'(rsp_ok);
      if (redirect_valid) begin
        if (redirect_target[1:0] == 2'b00) begin
          pc <= redirect_target;
        end else begin
          pc            <= TRAP_VECTOR;
          misalign_addr <= redirect_target;
        end
        buffered <= '0;
        buf_rd   <= '0;
        buf_wr   <= '0;
        pcq_rd   <= '0;
        pcq_wr   <= '0;
        // Everything still in flight after this cycle's response belongs to the old path.
        drop_cnt <= outstanding - CW'(rsp_ok);
      end else begin
        if (accept) begin
          pc          <= pc + 32'd4;
          pcq[pcq_wr] <= pc;
          pcq_wr      <= ptr_inc(pcq_wr);
        end
        if (rsp_ok && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if (rsp_keep) begin
          buf_data[buf_wr] <= imem_rsp_data;
          buf_pc[buf_wr]   <= pcq[pcq_rd];
          buf_wr           <= ptr_inc(buf_wr);
          pcq_rd           <= ptr_inc(pcq_rd);
        end
        if (pop) begin
          buf_rd <= ptr_inc(buf_rd);
        end
        buffered <= buffered + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  rsp_in_flight: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (outstanding != '0));

endmodule
